// File: rtl/vga_timing_pkg.sv
// Shared 800x600@60 timing constants and the per-axis phase type for the video sequencer.
package vga_timing_pkg;

  localparam int H_ACTIVE = 800;
  localparam int H_FP     = 40;
  localparam int H_SYNC   = 128;
  localparam int H_BP     = 88;
  localparam int V_ACTIVE = 600;
  localparam int V_FP     = 1;
  localparam int V_SYNC   = 4;
  localparam int V_BP     = 23;

  localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam int CW       = 11;
  localparam bit SYNC_POL = 1'b1;

  typedef enum logic [1:0] {
    PH_ACTIVE,
    PH_FP,
    PH_SYNC,
    PH_BP
  } phase_t;

  function automatic phase_t phase_succ(input phase_t ph);
    case (ph)
      PH_ACTIVE: phase_succ = PH_FP;
      PH_FP:     phase_succ = PH_SYNC;
      PH_SYNC:   phase_succ = PH_BP;
      default:   phase_succ = PH_ACTIVE;
    endcase
  endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// One timing axis: position counter plus phase FSM with registered sync/blank flags.
//   state     | meaning
//   PH_ACTIVE | visible region, blank low
//   PH_FP     | front porch, blank high
//   PH_SYNC   | sync pulse, sync at SYNC_POL, blank high
//   PH_BP     | back porch, blank high
module vga_axis_counter
  import vga_timing_pkg::*;
#(
  parameter int ACTIVE   = H_ACTIVE,
  parameter int FP       = H_FP,
  parameter int SYNC     = H_SYNC,
  parameter int BP       = H_BP,
  parameter bit SYNC_POL = 1'b1,
  parameter int CW       = 11
) (
  input  logic          pclk,
  input  logic          rst,
  input  logic          cnt_en,
  output logic [CW-1:0] count,
  output logic          wrap,
  output logic          sync,
  output logic          blnk
);

  localparam int TOTAL = ACTIVE + FP + SYNC + BP;

  if (ACTIVE < 1 || FP < 1 || SYNC < 1 || BP < 1 || TOTAL >= (2 ** CW)) begin : g_bad_params
    $error("vga_axis_counter: porch/sync widths must be nonzero and TOTAL must fit in CW bits");
  end

  localparam logic [CW-1:0] LAST_ACT  = CW'(ACTIVE - 1);
  localparam logic [CW-1:0] LAST_FP   = CW'(ACTIVE + FP - 1);
  localparam logic [CW-1:0] LAST_SYNC = CW'(ACTIVE + FP + SYNC - 1);
  localparam logic [CW-1:0] LAST_ALL  = CW'(TOTAL - 1);

  phase_t        phase;
  phase_t        phase_nxt;
  logic [CW-1:0] phase_last;
  logic          at_last;

  always_comb begin
    phase_last = LAST_ALL;
    case (phase)
      PH_ACTIVE: phase_last = LAST_ACT;
      PH_FP:     phase_last = LAST_FP;
      PH_SYNC:   phase_last = LAST_SYNC;
      default:   phase_last = LAST_ALL;
    endcase
  end

  assign at_last   = (count == phase_last);
  assign phase_nxt = phase_succ(phase);
  assign wrap      = cnt_en && (count == LAST_ALL);

  // Flags are computed from the phase being entered so they line up with the new count.
  always_ff @(posedge pclk or negedge rst) begin
    if (!rst) begin
      count <= '0;
      phase <= PH_ACTIVE;
      sync  <= ~SYNC_POL;
      blnk  <= 1'b0;
    end else if (cnt_en) begin
      count <= (count == LAST_ALL) ? '0 : count + 1'b1;
      if (at_last) begin
        phase <= phase_nxt;
        sync  <= (phase_nxt == PH_SYNC) ? SYNC_POL : ~SYNC_POL;
        blnk  <= (phase_nxt != PH_ACTIVE);
      end
    end
  end

endmodule

// File: rtl/vga_timing_ctrl.sv
// Master video sequencer: H/V timing axes plus frame_start and game_tick scheduling.
module vga_timing_ctrl
  import vga_timing_pkg::*;
#(
  parameter int H_ACTIVE = vga_timing_pkg::H_ACTIVE,
  parameter int H_FP     = vga_timing_pkg::H_FP,
  parameter int H_SYNC   = vga_timing_pkg::H_SYNC,
  parameter int H_BP     = vga_timing_pkg::H_BP,
  parameter int V_ACTIVE = vga_timing_pkg::V_ACTIVE,
  parameter int V_FP     = vga_timing_pkg::V_FP,
  parameter int V_SYNC   = vga_timing_pkg::V_SYNC,
  parameter int V_BP     = vga_timing_pkg::V_BP,
  parameter bit SYNC_POL = vga_timing_pkg::SYNC_POL,
  parameter int CW       = vga_timing_pkg::CW
) (
  input  logic          pclk,
  input  logic          rst,
  input  logic          en,
  input  logic [7:0]    frames_per_tick,
  output logic [CW-1:0] hcount,
  output logic [CW-1:0] vcount,
  output logic          hsync,
  output logic          vsync,
  output logic          hblnk,
  output logic          vblnk,
  output logic          frame_start,
  output logic          game_tick
);

  logic       h_wrap;
  logic       v_wrap;
  logic       v_en;
  logic       frame_wrap;
  logic [7:0] tick_cnt;
  logic [7:0] period;
  logic [7:0] period_req;
  logic [7:0] period_eff;

  assign v_en = en & h_wrap;

  vga_axis_counter #(
    .ACTIVE(H_ACTIVE), .FP(H_FP), .SYNC(H_SYNC), .BP(H_BP),
    .SYNC_POL(SYNC_POL), .CW(CW)
  ) u_h_axis (
    .pclk  (pclk),
    .rst   (rst),
    .cnt_en(en),
    .count (hcount),
    .wrap  (h_wrap),
    .sync  (hsync),
    .blnk  (hblnk)
  );

  vga_axis_counter #(
    .ACTIVE(V_ACTIVE), .FP(V_FP), .SYNC(V_SYNC), .BP(V_BP),
    .SYNC_POL(SYNC_POL), .CW(CW)
  ) u_v_axis (
    .pclk  (pclk),
    .rst   (rst),
    .cnt_en(v_en),
    .count (vcount),
    .wrap  (v_wrap),
    .sync  (vsync),
    .blnk  (vblnk)
  );

  // v_wrap already includes en & h_wrap, so this is the enabled edge into (0,0).
  assign frame_wrap = h_wrap & v_wrap;

  // A new period is only taken when the tick counter is back at zero.
  assign period_req = (frames_per_tick == 8'd0) ? 8'd1 : frames_per_tick;
  assign period_eff = (tick_cnt == 8'd0) ? period_req : period;

  always_ff @(posedge pclk or negedge rst) begin
    if (!rst) begin
      frame_start <= 1'b0;
      game_tick   <= 1'b0;
      tick_cnt    <= 8'd0;
      period      <= 8'd1;
    end else if (en) begin
      frame_start <= frame_wrap;
      game_tick   <= frame_wrap && (tick_cnt == 8'd0);
      if (frame_wrap) begin
        if (tick_cnt == 8'd0) begin
          period <= period_req;
        end
        tick_cnt <= (tick_cnt == period_eff - 8'd1) ? 8'd0 : tick_cnt + 8'd1;
      end
    end else begin
      frame_start <= 1'b0;
      game_tick   <= 1'b0;
    end
  end

endmodule

// File: tb/tb_vga_timing_ctrl.sv
// Randomized self-checking bench: a small-timing DUT against a position/frame model, plus a full 800x600 DUT.
module tb_vga_timing_ctrl;

  localparam int HA = 16, HF = 2, HS = 3, HB = 4;
  localparam int VA = 6,  VF = 1, VS = 2, VB = 3;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int FR = HT * VT;
  localparam bit POL = 1'b0;

  localparam int BHT = 1056, BVT = 628;

  logic       pclk = 1'b0;
  logic       rst;
  logic       en;
  logic [7:0] fpt;

  logic [4:0]  hcount, vcount;
  logic        hsync, vsync, hblnk, vblnk, frame_start, game_tick;
  logic [10:0] b_hcount, b_vcount;
  logic        b_hsync, b_vsync, b_hblnk, b_vblnk, b_frame_start, b_game_tick;

  int errors = 0;
  int checks = 0;

  always #5 pclk = ~pclk;

  vga_timing_ctrl #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .SYNC_POL(POL), .CW(5)
  ) dut (
    .pclk(pclk), .rst(rst), .en(en), .frames_per_tick(fpt),
    .hcount(hcount), .vcount(vcount), .hsync(hsync), .vsync(vsync),
    .hblnk(hblnk), .vblnk(vblnk), .frame_start(frame_start), .game_tick(game_tick)
  );

  vga_timing_ctrl dut_big (
    .pclk(pclk), .rst(rst), .en(1'b1), .frames_per_tick(8'd0),
    .hcount(b_hcount), .vcount(b_vcount), .hsync(b_hsync), .vsync(b_vsync),
    .hblnk(b_hblnk), .vblnk(b_vblnk), .frame_start(b_frame_start), .game_tick(b_game_tick)
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic int in_win(input int c, input int lo, input int len);
    return (c >= lo && c < lo + len) ? 1 : 0;
  endfunction

  // Model: linear position within the frame plus frame-level tick bookkeeping.
  int m_pos, m_tcnt, m_per, b_pos;
  bit m_fs, m_gt;
  int p_eff;
  always_comb p_eff = (m_tcnt == 0) ? ((fpt == 8'd0) ? 1 : int'(fpt)) : m_per;

  always @(posedge pclk or negedge rst) begin
    if (!rst) begin
      m_pos <= 0; m_tcnt <= 0; m_per <= 1; m_fs <= 1'b0; m_gt <= 1'b0; b_pos <= 0;
    end else begin
      b_pos <= (b_pos + 1) % (BHT * BVT);
      if (en) begin
        m_pos <= (m_pos + 1) % FR;
        m_fs  <= ((m_pos + 1) % FR == 0);
        m_gt  <= ((m_pos + 1) % FR == 0) && (m_tcnt == 0);
        if ((m_pos + 1) % FR == 0) begin
          m_per  <= p_eff;
          m_tcnt <= (m_tcnt + 1) % p_eff;
        end
      end else begin
        m_fs <= 1'b0;
        m_gt <= 1'b0;
      end
    end
  end

  always @(negedge pclk) begin
    chk("hcount", int'(hcount), m_pos % HT);
    chk("vcount", int'(vcount), m_pos / HT);
    chk("hsync", int'(hsync), in_win(m_pos % HT, HA + HF, HS) ? int'(POL) : int'(!POL));
    chk("vsync", int'(vsync), in_win(m_pos / HT, VA + VF, VS) ? int'(POL) : int'(!POL));
    chk("hblnk", int'(hblnk), (m_pos % HT >= HA) ? 1 : 0);
    chk("vblnk", int'(vblnk), (m_pos / HT >= VA) ? 1 : 0);
    chk("frame_start", int'(frame_start), int'(m_fs));
    chk("game_tick", int'(game_tick), int'(m_gt));
    chk("big_hcount", int'(b_hcount), b_pos % BHT);
    chk("big_vcount", int'(b_vcount), b_pos / BHT);
    chk("big_hsync", int'(b_hsync), in_win(b_pos % BHT, 840, 128));
    chk("big_vsync", int'(b_vsync), in_win(b_pos / BHT, 601, 4));
    chk("big_hblnk", int'(b_hblnk), (b_pos % BHT >= 800) ? 1 : 0);
    chk("big_vblnk", int'(b_vblnk), (b_pos / BHT >= 600) ? 1 : 0);
    chk("big_frame_start", int'(b_frame_start), 0);
  end

  task automatic step();
    @(negedge pclk);
    #1;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic do_reset();
    rst = 1'b0;
    steps(3);
    rst = 1'b1;
  endtask

  task automatic wait_pos(input int h, input int v, input int budget);
    int k;
    k = 0;
    while (!(int'(hcount) == h && int'(vcount) == v) && k < budget) begin
      step();
      k++;
    end
    if (k >= budget) begin
      errors++; checks++;
      $display("FAIL wait_pos(%0d,%0d): timeout after %0d cycles", h, v, budget);
    end
  endtask

  task automatic wait_fs(output bit tick);
    int k;
    k = 0;
    step();
    while (frame_start !== 1'b1 && k < 2 * FR) begin
      step();
      k++;
    end
    if (k >= 2 * FR) begin
      errors++; checks++;
      $display("FAIL wait_fs: timeout after %0d cycles", k);
    end
    tick = game_tick;
  endtask

  initial begin
    int  fs_seen;
    bit  tk;
    bit  ticks[7];
    rst = 1'b0;
    en  = 1'b1;
    fpt = 8'd3;
    steps(3);
    rst = 1'b1;

    // one full small frame: a single pulse, landing on (0,0) with a tick
    fs_seen = 0;
    for (int i = 0; i < FR; i++) begin
      step();
      if (frame_start) fs_seen++;
    end
    chk("first_frame_pulses", fs_seen, 1);
    chk("first_fs_h", int'(hcount), 0);
    chk("first_fs_v", int'(vcount), 0);
    chk("first_fs", int'(frame_start), 1);
    chk("first_tick", int'(game_tick), 1);

    // 800x600 instance boundary pins (big position == steps since release)
    steps(1000 - FR);
    chk("big_h1000", int'(b_hcount), 1000);
    chk("big_hsync_1000", int'(b_hsync), 0);
    chk("big_hblnk_1000", int'(b_hblnk), 1);
    steps(1056 + 839 - 1000);
    chk("big_h839", int'(b_hcount), 839);
    chk("big_v1", int'(b_vcount), 1);
    chk("big_hsync_839", int'(b_hsync), 0);
    step();
    chk("big_hsync_840", int'(b_hsync), 1);
    steps(127);
    chk("big_hsync_967", int'(b_hsync), 1);
    step();
    chk("big_hsync_968", int'(b_hsync), 0);

    // frames_per_tick = 3 over 7 frames -> ticks on frames 0,3,6
    fpt = 8'd3;
    do_reset();
    for (int f = 0; f < 7; f++) begin
      wait_fs(tk);
      ticks[f] = tk;
    end
    chk("fpt3_f0", int'(ticks[0]), 1);
    chk("fpt3_f1", int'(ticks[1]), 0);
    chk("fpt3_f2", int'(ticks[2]), 0);
    chk("fpt3_f3", int'(ticks[3]), 1);
    chk("fpt3_f5", int'(ticks[5]), 0);
    chk("fpt3_f6", int'(ticks[6]), 1);

    fpt = 8'd0;
    do_reset();
    for (int f = 0; f < 4; f++) begin
      wait_fs(tk);
      chk("fpt0_tick", int'(tk), 1);
    end

    // randomized enable, period changes and occasional resets
    for (int i = 0; i < 20000; i++) begin
      en = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 399) == 0) fpt = 8'($urandom_range(0, 5));
      if ($urandom_range(0, 4999) == 0) rst = 1'b0;
      step();
      rst = 1'b1;
    end

    // freeze at the last position, then resume into a single frame_start
    en = 1'b1;
    wait_pos(HT - 1, VT - 1, 2 * FR);
    en = 1'b0;
    steps(50);
    chk("frozen_h", int'(hcount), HT - 1);
    chk("frozen_v", int'(vcount), VT - 1);
    chk("frozen_fs", int'(frame_start), 0);
    en = 1'b1;
    step();
    chk("resume_h", int'(hcount), 0);
    chk("resume_v", int'(vcount), 0);
    chk("resume_fs", int'(frame_start), 1);

    // en dropped while frame_start is high
    wait_fs(tk);
    en = 1'b0;
    step();
    chk("drop_fs", int'(frame_start), 0);
    chk("drop_gt", int'(game_tick), 0);
    steps(5);
    en = 1'b1;
    fs_seen = 0;
    for (int i = 0; i < 30; i++) begin
      step();
      if (frame_start) fs_seen++;
    end
    chk("no_repeat_fs", fs_seen, 0);

    // async reset mid-frame at (20,7): every flag differs from its reset value
    wait_pos(20, 7, 2 * FR);
    chk("pre_rst_hblnk", int'(hblnk), 1);
    rst = 1'b0;
    #1;
    chk("async_h", int'(hcount), 0);
    chk("async_v", int'(vcount), 0);
    chk("async_hsync", int'(hsync), int'(!POL));
    chk("async_vsync", int'(vsync), int'(!POL));
    chk("async_hblnk", int'(hblnk), 0);
    chk("async_vblnk", int'(vblnk), 0);
    step();
    rst = 1'b1;
    fs_seen = 0;
    for (int i = 0; i < FR; i++) begin
      step();
      if (frame_start) fs_seen++;
    end
    chk("post_rst_pulses", fs_seen, 1);
    chk("post_rst_fs", int'(frame_start), 1);
    chk("post_rst_gt", int'(game_tick), 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
